// File: rtl/controlador_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_entrada
//  Description : Sequencer for the switch/button path used by the IN
//                instruction. On request from the control unit it stalls
//                the CPU, waits for a debounced press of the IN button,
//                captures the 8-bit switches sign-extended to 32 bits and
//                holds the word valid until the control unit acknowledges.
//                It re-arms only after the button is released, so one
//                physical press yields exactly one datum.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CICLOS : consecutive synchronized cycles the button must stay
//                      stable (press and release); legal range >= 2.
//    LARG_CONT       : width of the debounce counter.
//
//  Ports
//    clock       in   1  system clock, all state on rising edge
//    reset_n     in   1  asynchronous active-low reset
//    chaves      in   8  board switches, two's-complement value
//    botao       in   1  raw IN push-button, active-high, asynchronous
//    req_in      in   1  IN instruction in progress (level, held until ack)
//    ack         in   1  one-cycle pulse: dado consumed
//    dado        out 32  captured, sign-extended input word
//    dado_valido out  1  dado holds a fresh, unacknowledged value
//    aguardando  out  1  stall request while the input is pending
//    estado      out  3  current state encoding (debug/LEDs)
// ============================================================================
module controlador_entrada #(
    parameter int DEBOUNCE_CICLOS = 500000,
    parameter int LARG_CONT       = $clog2(DEBOUNCE_CICLOS)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  chaves,
    input  logic        botao,
    input  logic        req_in,
    input  logic        ack,
    output logic [31:0] dado,
    output logic        dado_valido,
    output logic        aguardando,
    output logic [2:0]  estado
);

    // ------------------------------------------------------------------------
    // State encoding. The numeric values are visible on the estado port and
    // are therefore part of the external interface.
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        OCIOSO = 3'd0,   // idle, waiting for an IN request
        ESPERA = 3'd1,   // request pending, waiting for the button
        FILTRO = 3'd2,   // button seen high, qualifying the press
        PRONTO = 3'd3,   // datum captured, waiting for ack
        SOLTAR = 3'd4    // waiting for a debounced release
    } estado_t;

    // Terminal count: the counter starts at zero on entry to a qualifying
    // state, so reaching this value on a still-stable input ends the window.
    localparam logic [LARG_CONT-1:0] C_ULTIMO = LARG_CONT'(DEBOUNCE_CICLOS - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                 sync1_q;      // first synchronizer stage
    logic                 sync2_q;      // second stage = synchronized button
    logic [7:0]           chaves_q;     // switches registered every cycle
    estado_t              estado_q;
    estado_t              estado_d;
    logic [LARG_CONT-1:0] cont_q;
    logic [LARG_CONT-1:0] cont_d;
    logic [31:0]          dado_q;
    logic [31:0]          dado_d;
    logic                 valido_q;
    logic                 valido_d;

    logic                 botao_s;

    assign botao_s = sync2_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        dado_d   = dado_q;
        valido_d = valido_q;

        case (estado_q)
            OCIOSO: begin
                if (req_in) begin
                    estado_d = ESPERA;
                end
            end

            ESPERA: begin
                if (!req_in) begin
                    estado_d = OCIOSO;
                end else if (botao_s) begin
                    estado_d = FILTRO;
                    cont_d   = '0;
                end
            end

            FILTRO: begin
                if (!req_in) begin
                    // Request withdrawn mid-qualification: nothing captured.
                    estado_d = OCIOSO;
                end else if (!botao_s) begin
                    // A bounce breaks the stable window; start over.
                    estado_d = ESPERA;
                    cont_d   = '0;
                end else if (cont_q == C_ULTIMO) begin
                    // Press qualified: capture the value registered on the
                    // previous edge, sign-extended to the datapath width.
                    estado_d = PRONTO;
                    dado_d   = {{24{chaves_q[7]}}, chaves_q};
                    valido_d = 1'b1;
                end else begin
                    cont_d = cont_q + LARG_CONT'(1);
                end
            end

            PRONTO: begin
                // ack wins over a simultaneous request drop so that a
                // consumed datum always goes through the release wait.
                if (ack) begin
                    estado_d = SOLTAR;
                    cont_d   = '0;
                    valido_d = 1'b0;
                end else if (!req_in) begin
                    estado_d = OCIOSO;
                    valido_d = 1'b0;
                end
            end

            SOLTAR: begin
                // Counts consecutive low samples; any high sample restarts
                // the window. req_in is deliberately not looked at here.
                if (botao_s) begin
                    cont_d = '0;
                end else if (cont_q == C_ULTIMO) begin
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_q + LARG_CONT'(1);
                end
            end

            default: begin
                // Unused encodings recover to idle.
                estado_d = OCIOSO;
                cont_d   = '0;
                valido_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers, synchronizer and switch register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            chaves_q <= 8'd0;
            estado_q <= OCIOSO;
            cont_q   <= '0;
            dado_q   <= 32'd0;
            valido_q <= 1'b0;
        end else begin
            sync1_q  <= botao;
            sync2_q  <= sync1_q;
            chaves_q <= chaves;
            estado_q <= estado_d;
            cont_q   <= cont_d;
            dado_q   <= dado_d;
            valido_q <= valido_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dado        = dado_q;
    assign dado_valido = valido_q;
    assign estado      = estado_q;

    // The stall drops in the same cycle as ack so the CPU can advance on the
    // cycle that consumes the datum.
    assign aguardando = (estado_q == ESPERA) ||
                        (estado_q == FILTRO) ||
                        ((estado_q == PRONTO) && !ack);

endmodule
`default_nettype wire

// File: tb/tb_controlador_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controlador_entrada
//  Description : Self-checking bench for controlador_entrada with a short
//                debounce window. A behavioural model tracks the transaction
//                phase and run lengths of the synchronized button and is
//                compared with the DUT every cycle; directed literal checks
//                pin the model to hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_entrada;

    localparam int D = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  chaves  = 8'd0;
    logic        botao   = 1'b0;
    logic        req_in  = 1'b0;
    logic        ack     = 1'b0;
    logic [31:0] dado;
    logic        dado_valido;
    logic        aguardando;
    logic [2:0]  estado;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   rises   = 0;
    logic prev_valid = 1'b0;

    always #5 clock = ~clock;

    controlador_entrada #(
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .chaves     (chaves),
        .botao      (botao),
        .req_in     (req_in),
        .ack        (ack),
        .dado       (dado),
        .dado_valido(dado_valido),
        .aguardando (aguardando),
        .estado     (estado)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: transaction phases, with the press qualified by the
    // length of the run of high synchronized samples seen while waiting
    // (one detection sample plus D filtered samples) and the release by a run
    // of D low samples.
    // ------------------------------------------------------------------------
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_HOLD = 2;
    localparam int M_REL  = 3;

    int          mode;
    int          run;
    int          lo;
    logic [1:0]  m_sync;
    logic [7:0]  m_ch;
    logic [31:0] m_dado;
    logic        m_valid;
    logic        m_bs;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode = M_IDLE; run = 0; lo = 0;
            m_sync = 2'b00; m_ch = 8'd0; m_dado = 32'd0; m_valid = 1'b0;
        end else begin
            m_bs = m_sync[1];
            case (mode)
                M_IDLE: if (req_in) begin mode = M_WAIT; run = 0; end
                M_WAIT: begin
                    if (!req_in) mode = M_IDLE;
                    else if (m_bs) begin
                        run++;
                        if (run == D + 1) begin
                            mode = M_HOLD;
                            m_dado = 32'($signed(m_ch));
                            m_valid = 1'b1;
                        end
                    end else run = 0;
                end
                M_HOLD: begin
                    if (ack) begin mode = M_REL; lo = 0; m_valid = 1'b0; end
                    else if (!req_in) begin mode = M_IDLE; m_valid = 1'b0; end
                end
                default: begin
                    if (m_bs) lo = 0;
                    else begin
                        lo++;
                        if (lo == D) mode = M_IDLE;
                    end
                end
            endcase
            m_sync = {m_sync[0], botao};
            m_ch   = chaves;
        end
    end

    logic [2:0] e_est;
    logic       e_agu;

    always @(negedge clock) begin
        case (mode)
            M_IDLE:  e_est = 3'd0;
            M_WAIT:  e_est = (run == 0) ? 3'd1 : 3'd2;
            M_HOLD:  e_est = 3'd3;
            default: e_est = 3'd4;
        endcase
        e_agu = (mode == M_WAIT) || ((mode == M_HOLD) && !ack);
        chk("model estado", 32'(estado), 32'(e_est));
        chk("model dado", dado, m_dado);
        chk("model dado_valido", 32'(dado_valido), 32'(m_valid));
        chk("model aguardando", 32'(aguardando), 32'(e_agu));
        if (dado_valido && !prev_valid) rises++;
        prev_valid = dado_valido;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Full IN transaction with the button released right after ack.
    task automatic do_in(input logic [7:0] ch, input logic [31:0] exp_d, input string nm);
        chaves = ch; req_in = 1'b1;
        tick(1);
        chk({nm, " aguardando in ESPERA"}, 32'(aguardando), 32'd1);
        botao = 1'b1;
        tick(6);
        chk({nm, " valid not yet"}, 32'(dado_valido), 32'd0);
        tick(1);
        chk({nm, " valid after 2+4"}, 32'(dado_valido), 32'd1);
        chk({nm, " dado"}, dado, exp_d);
        ack = 1'b1; #1;
        chk({nm, " aguardando on ack"}, 32'(aguardando), 32'd0);
        tick(1);
        ack = 1'b0; req_in = 1'b0;
        chk({nm, " valid cleared"}, 32'(dado_valido), 32'd0);
        chk({nm, " estado SOLTAR"}, 32'(estado), 32'd4);
        botao = 1'b0;
        tick(8);
        chk({nm, " back to OCIOSO"}, 32'(estado), 32'd0);
    endtask

    initial begin
        tick(3);
        chk("reset estado", 32'(estado), 32'd0);
        chk("reset dado", dado, 32'd0);
        chk("reset valid", 32'(dado_valido), 32'd0);
        chk("reset aguardando", 32'(aguardando), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic capture and sign extension
        do_in(8'h05, 32'h00000005, "in05");
        do_in(8'hFB, 32'hFFFFFFFB, "inFB");
        do_in(8'h80, 32'hFFFFFF80, "in80");

        // Bounce: high 2, low 1, high 5
        chaves = 8'hC3; req_in = 1'b1;
        tick(1);
        rises = 0;
        botao = 1'b1; tick(2);
        botao = 1'b0; tick(1);
        botao = 1'b1; tick(5);
        botao = 1'b0;
        tick(1);
        chk("bounce valid not yet", 32'(dado_valido), 32'd0);
        tick(1);
        chk("bounce valid", 32'(dado_valido), 32'd1);
        chk("bounce dado", dado, 32'hFFFFFFC3);
        ack = 1'b1; tick(1);
        ack = 1'b0; req_in = 1'b0;
        tick(8);
        chk("bounce single rise", 32'(rises), 32'd1);

        // Button held across ack and a second request
        chaves = 8'h11; req_in = 1'b1;
        tick(1);
        botao = 1'b1; tick(7);
        chk("held dado", dado, 32'h00000011);
        ack = 1'b1; tick(1);
        ack = 1'b0; req_in = 1'b0;
        tick(2);
        chaves = 8'h22; req_in = 1'b1;
        tick(5);
        chk("held stays SOLTAR", 32'(estado), 32'd4);
        chk("held no new capture", dado, 32'h00000011);
        chk("held valid low", 32'(dado_valido), 32'd0);
        chk("held no stall", 32'(aguardando), 32'd0);
        botao = 1'b0;
        tick(6);
        chk("release to OCIOSO", 32'(estado), 32'd0);
        tick(1);
        chk("rearm to ESPERA", 32'(estado), 32'd1);
        botao = 1'b1; tick(6);
        chk("second press not yet", 32'(dado_valido), 32'd0);
        tick(1);
        chk("second press dado", dado, 32'h00000022);
        ack = 1'b1; tick(1);
        ack = 1'b0; req_in = 1'b0; botao = 1'b0;
        tick(8);

        // req_in dropped in FILTRO (ack in ESPERA ignored first)
        chaves = 8'h3C; req_in = 1'b1;
        tick(1);
        ack = 1'b1; tick(1);
        ack = 1'b0;
        chk("ack ignored in ESPERA", 32'(estado), 32'd1);
        botao = 1'b1; tick(4);
        chk("in FILTRO", 32'(estado), 32'd2);
        req_in = 1'b0; tick(1);
        chk("abort FILTRO estado", 32'(estado), 32'd0);
        chk("abort FILTRO dado", dado, 32'h00000022);
        chk("abort FILTRO valid", 32'(dado_valido), 32'd0);
        botao = 1'b0; tick(4);

        // req_in dropped in PRONTO without ack
        chaves = 8'h7F; req_in = 1'b1;
        tick(1);
        botao = 1'b1; tick(7);
        chk("PRONTO valid", 32'(dado_valido), 32'd1);
        req_in = 1'b0; tick(1);
        chk("abort PRONTO estado", 32'(estado), 32'd0);
        chk("abort PRONTO valid", 32'(dado_valido), 32'd0);
        chk("abort PRONTO dado kept", dado, 32'h0000007F);
        botao = 1'b0; tick(4);

        // Asynchronous reset mid-FILTRO
        req_in = 1'b1;
        tick(1);
        botao = 1'b1; tick(4);
        chk("pre-reset FILTRO", 32'(estado), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset estado", 32'(estado), 32'd0);
        chk("async reset dado", dado, 32'd0);
        chk("async reset valid", 32'(dado_valido), 32'd0);
        chk("async reset aguardando", 32'(aguardando), 32'd0);
        tick(2);
        reset_n = 1'b1; req_in = 1'b0; botao = 1'b0;
        tick(3);
        chk("post-reset idle", 32'(estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
